regfile_mp_m: RTL and testbench
===============================

Name: regfile_mp_m

Overview:
- Parametrised multi-read-port register file for the urv core; successor to the current 32x32 one-write/one-read array.
- Width, depth and read-port count are parameters. Provides a hardwired-zero entry 0, write-to-read bypass, and a selectable registered or combinational read path.
- After reset it self-clears every entry with an init sequencer, so the core never reads X state.

Parameters:
DATA_W, 32, data width per entry
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
NRD, 2, number of independent read ports (1..4)
SYNC_RD, 0, 0 = combinational read; 1 = registered read, 1-cycle latency
BYPASS, 1, 1 = a same-cycle write to the read address is forwarded to the read data
ZERO_R0, 1, 1 = entry 0 always reads 0 and writes to it are discarded

Ports:
wclk  in  1  clock
rst  in  1  asynchronous, active-low reset
we  in  1  write enable
waddr  in  ADDR_W  write address
di  in  DATA_W  write data
raddr  in  NRD*ADDR_W  packed read addresses; port k = bits [k*ADDR_W +: ADDR_W]
do  out  NRD*DATA_W  packed read data; port k = bits [k*DATA_W +: DATA_W]
ready  out  1  high once the init sweep is complete
wr_drop  out  1  one-cycle pulse when a write is ignored because ready=0
perr_inject  in  1  flip the stored parity of the current write (used only with the feature)
perr  out  1  sticky parity error flag (feature only; otherwise 0)
perr_port  out  NRD  per-port parity error, valid with read data (feature only; otherwise 0)

Behaviour:
- Reset: reset rst, asynchronous, active-low; clock wclk.
- While rst=0: ready=0, wr_drop=0, perr=0, perr_port=0, registered do=0, init counter=0, FSM=INIT.
- FSM states: INIT, RUN.
- INIT:
  - Each wclk edge writes 0 to entry cnt, then cnt increments.
  - When cnt==DEPTH-1 is written, go to RUN and set ready=1 on the same edge. INIT therefore lasts exactly DEPTH cycles after rst deasserts.
  - External we is ignored; wr_drop=1 in any INIT cycle with we=1.
  - All do read 0 regardless of raddr.
- RUN:
  - we=1 writes di to waddr on the rising edge.
  - If ZERO_R0=1 and waddr==0, the write is discarded; no wr_drop.
  - RUN is left only by rst.
- Read, SYNC_RD=0: do[k] = the array value at raddr[k], combinational.
- Read, SYNC_RD=1: do[k] is registered and reflects raddr[k] sampled at the previous edge.
- Bypass (BYPASS=1, RUN): if we=1 and waddr==raddr[k] and the write is not discarded, port k returns di. In SYNC_RD=1 mode the forwarded value is registered. Without bypass, a same-cycle read returns the old value.
- Zero entry (ZERO_R0=1): raddr[k]==0 returns 0 in all cases.
- Multiple ports may read the same address simultaneously; each returns identical data.
- Reset asserted mid-operation (INIT or RUN): immediately back to INIT. Array contents are undefined until the new sweep completes.

Optional Feature:
- Macro: REGFILE_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit computed from di. The init sweep writes parity 0.
  - perr_inject=1 with a RUN write stores inverted parity.
  - On read, perr_port[k]=1 when the parity check fails for a non-bypassed, non-zero-entry read, timed with do[k] (combinational, or registered when SYNC_RD=1).
  - perr is set on any perr_port bit and is cleared only by rst.
- Not defined:
  - No parity storage.
  - perr and perr_port are tied 0; perr_inject is ignored.

Test Plan:
- Init sweep, DEPTH=32: release rst, assert we with waddr=3, di=32'h1234 in cycle 5 -> wr_drop=1 that cycle; ready rises after exactly 32 cycles; raddr=3 then reads 0.
- Basic write/read, SYNC_RD=0: write 32'hDEADBEEF to entry 7, then 32'h0000_00A5 to entry 31; port0 raddr=7, port1 raddr=31 -> do = {32'hA5, 32'hDEADBEEF} in the same cycle.
- Bypass, SYNC_RD=1: entry 9 holds 32'h11; write 32'h22 to 9 while raddr[0]=9 -> do[0]=32'h22 on the next cycle. With BYPASS=0 -> 32'h11, then 32'h22 one cycle later.
- Zero entry: write 32'hFFFFFFFF to entry 0 -> both ports read 0 from entry 0; no wr_drop.
- Reset mid-RUN: write 32'h55 to entry 4, pulse rst low for 3 ns between clock edges -> ready drops asynchronously; after 32 cycles entry 4 reads 0.
- Parity, REGFILE_PARITY_EN defined: write 32'h3 to entry 12 with perr_inject=1, read entry 12 on port 1 -> perr_port=2'b10 and perr=1; perr stays 1 after further good reads until rst.

Source files
------------

// File: rtl/regfile_mp_m.sv
// Multi-read-port register file with a hardwired-zero entry, write-to-read bypass
// and a post-reset zeroing sweep. Optional parity storage when REGFILE_PARITY_EN is defined.
module regfile_mp_m #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NRD     = 2,
    parameter int SYNC_RD = 0,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic                  wclk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     di,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] dout,     // read data; "do" is a reserved word
    output logic                  ready,
    output logic                  wr_drop,
    input  logic                  perr_inject,
    output logic                  perr,
    output logic [NRD-1:0]        perr_port
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              perr_q, perr_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_zero, wr_run;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_waddr_d;
    logic [DATA_W-1:0] mem_wdata_d;

    logic [ADDR_W-1:0] ra [NRD];
    logic [DATA_W-1:0] rd_d [NRD];
    logic [NRD-1:0]    pe_d;
    logic [NRD-1:0]    perr_port_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == ST_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wclk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            perr_q  <= perr_d;
        end
    end

    // The sweep owns the write port until ready; external writes are dropped meanwhile.
    assign wr_zero = (ZERO_R0 != 0) && (waddr == '0);
    assign wr_run  = ready_q && we && !wr_zero;
    assign wr_drop = rst && !ready_q && we;

    always_comb begin
        mem_we_d    = !ready_q || wr_run;
        mem_waddr_d = ready_q ? waddr : cnt_q;
        mem_wdata_d = ready_q ? di : '0;
    end

    always_ff @(posedge wclk) begin
        if (mem_we_d) begin
            mem_q[mem_waddr_d] <= mem_wdata_d;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic par_q [DEPTH];
    logic par_wdata_d;

    assign par_wdata_d = ready_q ? ((^di) ^ perr_inject) : 1'b0;

    always_ff @(posedge wclk) begin
        if (mem_we_d) begin
            par_q[mem_waddr_d] <= par_wdata_d;
        end
    end
`else
    logic unused_perr_inject;
    assign unused_perr_inject = perr_inject;
`endif

    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            ra[k]   = raddr[k*ADDR_W +: ADDR_W];
            rd_d[k] = '0;
            pe_d[k] = 1'b0;
            if (!ready_q || ((ZERO_R0 != 0) && (ra[k] == '0))) begin
                rd_d[k] = '0;
            end else if ((BYPASS != 0) && wr_run && (waddr == ra[k])) begin
                rd_d[k] = di;
            end else begin
                rd_d[k] = mem_q[ra[k]];
`ifdef REGFILE_PARITY_EN
                pe_d[k] = (^mem_q[ra[k]]) != par_q[ra[k]];
`endif
            end
        end
    end

    // Sticky flag samples the pre-register check so it rises with a registered perr_port.
    assign perr_d = perr_q || (|pe_d);

    if (SYNC_RD != 0) begin : g_sync
        logic [DATA_W-1:0] rd_q [NRD];
        logic [NRD-1:0]    pe_q;

        always_ff @(posedge wclk or negedge rst) begin
            if (!rst) begin
                for (int k = 0; k < NRD; k++) begin
                    rd_q[k] <= '0;
                end
                pe_q <= '0;
            end else begin
                for (int k = 0; k < NRD; k++) begin
                    rd_q[k] <= rd_d[k];
                end
                pe_q <= pe_d;
            end
        end

        for (genvar k = 0; k < NRD; k++) begin : g_port
            assign dout[k*DATA_W +: DATA_W] = rd_q[k];
        end
        assign perr_port_i = pe_q;
    end else begin : g_comb
        for (genvar k = 0; k < NRD; k++) begin : g_port
            assign dout[k*DATA_W +: DATA_W] = rd_d[k];
        end
        assign perr_port_i = pe_d;
    end

    assign ready     = ready_q;
    assign perr      = perr_q;
    assign perr_port = perr_port_i;

endmodule

// File: tb/tb_regfile_mp_m.sv
// Directed bench for regfile_mp_m: combinational, registered-with-bypass and
// registered-without-bypass instances driven from the same stimulus.
module tb_regfile_mp_m;
    logic        wclk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] di;
    logic [9:0]  raddr;
    logic        perr_inject;

    logic [63:0] dout_c, dout_s, dout_n;
    logic        ready_c, ready_s, ready_n;
    logic        wr_drop_c, wr_drop_s, wr_drop_n;
    logic        perr_c, perr_s, perr_n;
    logic [1:0]  pp_c, pp_s, pp_n;

    int n_cmp = 0;
    int n_err = 0;

`ifdef REGFILE_PARITY_EN
    localparam logic [1:0] EXP_PP   = 2'b10;
    localparam logic       EXP_PERR = 1'b1;
`else
    localparam logic [1:0] EXP_PP   = 2'b00;
    localparam logic       EXP_PERR = 1'b0;
`endif

    regfile_mp_m u_c (
        .wclk(wclk), .rst(rst), .we(we), .waddr(waddr), .di(di), .raddr(raddr),
        .dout(dout_c), .ready(ready_c), .wr_drop(wr_drop_c),
        .perr_inject(perr_inject), .perr(perr_c), .perr_port(pp_c)
    );

    regfile_mp_m #(.SYNC_RD(1), .BYPASS(1)) u_s (
        .wclk(wclk), .rst(rst), .we(we), .waddr(waddr), .di(di), .raddr(raddr),
        .dout(dout_s), .ready(ready_s), .wr_drop(wr_drop_s),
        .perr_inject(perr_inject), .perr(perr_s), .perr_port(pp_s)
    );

    regfile_mp_m #(.SYNC_RD(1), .BYPASS(0)) u_n (
        .wclk(wclk), .rst(rst), .we(we), .waddr(waddr), .di(di), .raddr(raddr),
        .dout(dout_n), .ready(ready_n), .wr_drop(wr_drop_n),
        .perr_inject(perr_inject), .perr(perr_n), .perr_port(pp_n)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct packed {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] di;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [63:0] exp_byp;
        logic [63:0] exp_nobyp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // {port1, port0} packing for the expected read data.
        vecs[0] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd7,  5'd31, 64'h00000000_DEADBEEF, 64'h00000000_00000000};
        vecs[1] = '{1'b1, 5'd31, 32'h000000A5, 5'd7,  5'd31, 64'h000000A5_DEADBEEF, 64'h00000000_DEADBEEF};
        vecs[2] = '{1'b0, 5'd0,  32'h00000000, 5'd7,  5'd31, 64'h000000A5_DEADBEEF, 64'h000000A5_DEADBEEF};
        vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  64'h00000000_00000000, 64'h00000000_00000000};
        vecs[4] = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd0,  64'h00000000_00000000, 64'h00000000_00000000};
        vecs[5] = '{1'b0, 5'd0,  32'h00000000, 5'd31, 5'd7,  64'hDEADBEEF_000000A5, 64'hDEADBEEF_000000A5};
        vecs[6] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  64'h12345678_12345678, 64'hDEADBEEF_DEADBEEF};
        vecs[7] = '{1'b0, 5'd0,  32'h00000000, 5'd7,  5'd7,  64'h12345678_12345678, 64'h12345678_12345678};
        vecs[8] = '{1'b1, 5'd5,  32'hCAFEF00D, 5'd5,  5'd9,  64'h00000000_CAFEF00D, 64'h00000000_00000000};
        vecs[9] = '{1'b0, 5'd0,  32'h00000000, 5'd9,  5'd5,  64'hCAFEF00D_00000000, 64'hCAFEF00D_00000000};

        rst = 1'b0; we = 1'b0; waddr = '0; di = '0; raddr = '0; perr_inject = 1'b0;
        repeat (3) @(posedge wclk);
        #1;
        we = 1'b1; waddr = 5'd3; di = 32'h1234;
        #1;
        chk("rst_ready", ready_c, 0);
        chk("rst_wr_drop", wr_drop_c, 0);
        chk("rst_dout_s", dout_s, 0);
        chk("rst_perr", perr_s, 0);
        we = 1'b0;
        rst = 1'b1;
        raddr = {5'd3, 5'd3};

        // Init sweep: 32 edges, a write attempt in cycle 5 is dropped.
        for (int i = 1; i <= 32; i++) begin
            we = (i == 5);
            @(negedge wclk);
            if (i == 4 || i == 5) chk($sformatf("init_wr_drop_c%0d", i), wr_drop_c, (i == 5));
            chk($sformatf("init_ready_c%0d", i), ready_c, 0);
            chk($sformatf("init_dout_c%0d", i), dout_c, 0);
            @(posedge wclk);
            #1;
        end
        chk("ready_after_32", ready_c, 1);
        chk("ready_s_after_32", ready_s, 1);
        we = 1'b0;
        @(negedge wclk);
        chk("read_e3_after_init", dout_c, 0);
        @(posedge wclk);
        #1;

        for (int i = 0; i < 10; i++) begin
            we = vecs[i].we; waddr = vecs[i].wa; di = vecs[i].di;
            raddr = {vecs[i].ra1, vecs[i].ra0};
            @(negedge wclk);
            chk($sformatf("row%0d_dout_c", i), dout_c, vecs[i].exp_byp);
            chk($sformatf("row%0d_wr_drop", i), wr_drop_c, 0);
            @(posedge wclk);
            #1;
            chk($sformatf("row%0d_dout_s", i), dout_s, vecs[i].exp_byp);
            chk($sformatf("row%0d_dout_n", i), dout_n, vecs[i].exp_nobyp);
        end

        // Registered-read bypass on entry 9.
        we = 1'b1; waddr = 5'd9; di = 32'h11; raddr = '0;
        @(posedge wclk);
        #1;
        we = 1'b1; waddr = 5'd9; di = 32'h22; raddr = {5'd0, 5'd9};
        @(posedge wclk);
        #1;
        chk("byp_sync_s", dout_s, 64'h22);
        chk("byp_sync_n_old", dout_n, 64'h11);
        we = 1'b0;
        @(posedge wclk);
        #1;
        chk("byp_sync_n_new", dout_n, 64'h22);
        chk("byp_sync_s_hold", dout_s, 64'h22);

        // Parity: corrupted write to entry 12, read on port 1.
        we = 1'b1; waddr = 5'd12; di = 32'h3; perr_inject = 1'b1; raddr = {5'd4, 5'd4};
        @(posedge wclk);
        #1;
        we = 1'b0; perr_inject = 1'b0; raddr = {5'd12, 5'd4};
        @(negedge wclk);
        chk("par_dout_c", dout_c, 64'h00000003_00000000);
        chk("par_pp_c", pp_c, EXP_PP);
        @(posedge wclk);
        #1;
        chk("par_perr_c", perr_c, EXP_PERR);
        chk("par_pp_s", pp_s, EXP_PP);
        chk("par_perr_s", perr_s, EXP_PERR);
        raddr = {5'd4, 5'd4};
        @(posedge wclk);
        #1;
        @(negedge wclk);
        chk("par_good_pp_c", pp_c, 0);
        chk("par_sticky_c", perr_c, EXP_PERR);
        chk("par_sticky_s", perr_s, EXP_PERR);
        @(posedge wclk);
        #1;

        // Reset pulse mid-RUN clears ready, perr and re-zeroes the array.
        we = 1'b1; waddr = 5'd4; di = 32'h55; raddr = {5'd4, 5'd4};
        @(posedge wclk);
        #1;
        we = 1'b0;
        #1;
        chk("pre_rst_e4", dout_c, 64'h00000055_00000055);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", ready_c, 0);
        chk("mid_rst_perr", perr_c, 0);
        chk("mid_rst_dout_s", dout_s, 0);
        #2;
        rst = 1'b1;
        n = 0;
        while (ready_c !== 1'b1 && n < 40) begin
            @(posedge wclk);
            #1;
            n++;
        end
        chk("reinit_cycles", n, 32);
        @(negedge wclk);
        chk("reinit_e4_zero", dout_c, 0);
        @(posedge wclk);
        #1;
        chk("reinit_e4_zero_s", dout_s, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
